// File: rtl/beam_select_gather_pkg.sv
// Shared types for the sorted-beam gather path: index vector, fetch states and
// the index range helper used when BEAM_SELECT_IDX_CHECK_EN is defined.
package beam_pkg;
    localparam int NBEAM  = 16;
    localparam int BIDX_W = 8;

    typedef logic [NBEAM-1:0][BIDX_W-1:0] beam_idx_vec_t;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_FULL = 2'd2
    } fetch_state_t;

    function automatic logic idx_in_range(input logic [BIDX_W-1:0] idx, input int col);
        return int'(idx) < col;
    endfunction
endpackage

// File: rtl/beam_select_gather_if.sv
// Stream, index-BRAM and status signals of beam_select_gather.
// slave is the gather block, master is whoever drives the input stream and BRAM.
interface beam_select_gather_if #(
    parameter int IW  = 32,
    parameter int COL = 64
) ();
    import beam_pkg::*;

    logic                         sop;
    logic [COL-1:0][IW-1:0]       in_data;
    logic                         in_tvalid;
    logic [7:0]                   rbg_max;
    logic                         bid_rden;
    beam_idx_vec_t                beam_index;
    logic [NBEAM-1:0][IW-1:0]     out_data;
    beam_idx_vec_t                beam_id;
    logic                         out_tvalid;
    logic                         out_sop;
    logic                         out_eop;
    logic [7:0]                   rbg_idx;
    logic [1:0]                   err;

    modport slave (
        input  sop, in_data, in_tvalid, rbg_max, beam_index,
        output bid_rden, out_data, beam_id, out_tvalid, out_sop, out_eop, rbg_idx, err
    );

    modport master (
        output sop, in_data, in_tvalid, rbg_max, beam_index,
        input  bid_rden, out_data, beam_id, out_tvalid, out_sop, out_eop, rbg_idx, err
    );
endinterface

// File: rtl/beam_gather_lane.sv
// One output lane: registered COL:1 column select driven by a beam index.
// BEAM_SELECT_IDX_CHECK_EN zeroes the lane and flags indices >= COL; otherwise the index wraps modulo COL.
module beam_gather_lane
    import beam_pkg::*;
#(
    parameter int IW  = 32,
    parameter int COL = 64
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   en,
    input  logic [COL-1:0][IW-1:0] col_data,
    input  logic [BIDX_W-1:0]      idx,
    output logic                   oor,
    output logic [IW-1:0]          lane_data
);
    localparam int SEL_W = $clog2(COL);

    logic [SEL_W-1:0] sel;
    assign sel = idx[SEL_W-1:0];

`ifdef BEAM_SELECT_IDX_CHECK_EN
    assign oor = !idx_in_range(idx, COL);
`else
    logic unused_idx_hi;
    assign unused_idx_hi = ^idx[BIDX_W-1:SEL_W];
    assign oor = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lane_data <= '0;
        end else if (en) begin
            lane_data <= oor ? '0 : col_data[sel];
        end
    end
endmodule

// File: rtl/beam_select_gather.sv
// Fetches the top-NBEAM beam indices per RBG from the sorter BRAM and gathers those
// columns out of the COL-wide stream. Range checking is enabled by BEAM_SELECT_IDX_CHECK_EN.
//
// state  | meaning
// F_IDLE | no fetch outstanding, waiting for i_sop
// F_WAIT | read issued, counting down the BRAM latency
// F_FULL | shadow holds the indices for the next RBG
module beam_select_gather
    import beam_pkg::*;
#(
    parameter int IW      = 32,
    parameter int COL     = 64,
    parameter int RD_LAT  = 4,
    parameter int RBG_LEN = 48
) (
    input logic                  i_clk,
    input logic                  i_reset,
    beam_select_gather_if.slave  bus
);
    localparam int LAT_W  = $clog2(RD_LAT + 1);
    localparam int BEAT_W = $clog2(RBG_LEN);

    fetch_state_t      state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [7:0]        rbg_cnt;
    logic [7:0]        rbg_max_q;
    beam_idx_vec_t     shadow;
    beam_idx_vec_t     active;
    logic              rden_q;
    logic [1:0]        err_q;
    logic              ovalid_q;
    logic              osop_q;
    logic              oeop_q;
    logic [7:0]        orbg_q;
    beam_idx_vec_t     obid_q;

    logic [BEAT_W-1:0] beat_eff;
    logic [7:0]        rbg_eff;
    logic [7:0]        rbg_max_eff;
    logic              first_beat;
    logic              last_beat;
    logic              swap;
    logic              underrun;
    logic              range_err;
    beam_idx_vec_t     sel_idx;

    logic [NBEAM-1:0][IW-1:0] lane_data;
    logic [NBEAM-1:0]         lane_oor;

    // A beat coinciding with i_sop is beat 0 of RBG 0 under the newly sampled rbg_max.
    always_comb begin
        beat_eff    = bus.sop ? '0 : beat_cnt;
        rbg_eff     = bus.sop ? '0 : rbg_cnt;
        rbg_max_eff = bus.sop ? bus.rbg_max : rbg_max_q;
        first_beat  = bus.in_tvalid && (beat_eff == '0);
        last_beat   = (beat_eff == BEAT_W'(RBG_LEN - 1));
        swap        = first_beat && (state == F_FULL);
        underrun    = first_beat && (state != F_FULL);
        sel_idx     = swap ? shadow : active;
        range_err   = swap && (|lane_oor);
    end

    for (genvar k = 0; k < NBEAM; k++) begin : g_lane
        beam_gather_lane #(
            .IW  (IW),
            .COL (COL)
        ) u_lane (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .en        (bus.in_tvalid),
            .col_data  (bus.in_data),
            .idx       (sel_idx[k]),
            .oor       (lane_oor[k]),
            .lane_data (lane_data[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= F_IDLE;
            lat_cnt   <= '0;
            beat_cnt  <= '0;
            rbg_cnt   <= '0;
            rbg_max_q <= '0;
            shadow    <= '0;
            active    <= '0;
            rden_q    <= 1'b0;
            err_q     <= '0;
            ovalid_q  <= 1'b0;
            osop_q    <= 1'b0;
            oeop_q    <= 1'b0;
            orbg_q    <= '0;
            obid_q    <= '0;
        end else begin
            rden_q <= 1'b0;
            if (underrun) err_q[0] <= 1'b1;
            if (range_err) err_q[1] <= 1'b1;
            if (swap) active <= shadow;

            // A new symbol always restarts the fetch; abandoning one in flight is an error.
            if (bus.sop) begin
                rbg_max_q <= bus.rbg_max;
                rden_q    <= 1'b1;
                lat_cnt   <= LAT_W'(RD_LAT);
                state     <= F_WAIT;
                if (state == F_WAIT) err_q[0] <= 1'b1;
            end else begin
                case (state)
                    F_IDLE: state <= F_IDLE;
                    F_WAIT: begin
                        if (lat_cnt == '0) begin
                            shadow <= bus.beam_index;
                            state  <= F_FULL;
                        end else begin
                            lat_cnt <= lat_cnt - 1'b1;
                        end
                    end
                    F_FULL: begin
                        if (first_beat) begin
                            if (rbg_eff < rbg_max_eff) begin
                                rden_q  <= 1'b1;
                                lat_cnt <= LAT_W'(RD_LAT);
                                state   <= F_WAIT;
                            end else begin
                                state <= F_IDLE;
                            end
                        end
                    end
                    default: state <= F_IDLE;
                endcase
            end

            if (bus.in_tvalid) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    rbg_cnt  <= (rbg_eff == rbg_max_eff) ? 8'd0 : rbg_eff + 8'd1;
                end else begin
                    beat_cnt <= beat_eff + 1'b1;
                    rbg_cnt  <= rbg_eff;
                end
            end else if (bus.sop) begin
                beat_cnt <= '0;
                rbg_cnt  <= '0;
            end

            ovalid_q <= bus.in_tvalid;
            osop_q   <= bus.in_tvalid && (beat_eff == '0) && (rbg_eff == 8'd0);
            oeop_q   <= bus.in_tvalid && last_beat && (rbg_eff == rbg_max_eff);
            if (bus.in_tvalid) begin
                orbg_q <= rbg_eff;
                obid_q <= sel_idx;
            end
        end
    end

    assign bus.bid_rden   = rden_q;
    assign bus.out_data   = lane_data;
    assign bus.beam_id    = obid_q;
    assign bus.out_tvalid = ovalid_q;
    assign bus.out_sop    = osop_q;
    assign bus.out_eop    = oeop_q;
    assign bus.rbg_idx    = orbg_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_beam_select_gather.sv
// Randomized scoreboard bench for beam_select_gather with a timing-level reference model
// and a BRAM model that presents each fetch's indices for exactly one cycle.
`timescale 1ns/1ps
module tb_beam_select_gather;
    import beam_pkg::*;

    localparam int IW      = 32;
    localparam int COL     = 64;
    localparam int RD_LAT  = 4;
    localparam int RBG_LEN = 48;
    localparam int NFETCH  = 64;

    typedef struct {
        logic [NBEAM-1:0][IW-1:0] data;
        beam_idx_vec_t            ids;
        logic                     sop;
        logic                     eop;
        logic [7:0]               rbg;
        logic [1:0]               err;
    } exp_t;

    typedef struct {
        int            cyc;
        beam_idx_vec_t v;
    } bram_t;

    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    beam_select_gather_if #(.IW(IW), .COL(COL)) bus ();

    beam_select_gather #(
        .IW      (IW),
        .COL     (COL),
        .RD_LAT  (RD_LAT),
        .RBG_LEN (RBG_LEN)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    exp_t          sb_q[$];
    int            rden_q[$];
    bram_t         bram_q[$];
    beam_idx_vec_t tab[NFETCH];
    int            bram_n = 0;
    int            cyc = 0;
    int            checks = 0;
    int            passes = 0;

    // Reference model state: beats since the last sop, fetch availability by cycle number.
    int            m_beats;
    int            m_rbg_max;
    bit            m_pending;
    int            m_ready;
    int            m_fetch = 0;
    beam_idx_vec_t m_shadow;
    beam_idx_vec_t m_active;
    logic [1:0]    m_err;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (bus.out_tvalid === 1'b1) begin
            chk("beat_expected", 512'(sb_q.size() != 0), 512'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("data", bus.out_data, e.data);
                chk("beam_id", 512'(bus.beam_id), 512'(e.ids));
                chk("sop_eop_rbg", 512'({bus.out_sop, bus.out_eop, bus.rbg_idx}), 512'({e.sop, e.eop, e.rbg}));
                chk("err", 512'(bus.err), 512'(e.err));
            end
        end
        if (bus.bid_rden === 1'b1) begin
            chk("rden_expected", 512'(rden_q.size() != 0), 512'(1));
            if (rden_q.size() != 0) chk("rden_cycle", 512'(cyc), 512'(rden_q.pop_front()));
            bram_q.push_back('{cyc + RD_LAT, tab[bram_n % NFETCH]});
            bram_n++;
        end
    end

    task automatic model_reset();
        m_beats   = 0;
        m_rbg_max = 0;
        m_pending = 1'b0;
        m_ready   = 0;
        m_shadow  = '0;
        m_active  = '0;
        m_err     = '0;
    endtask

    task automatic step(input bit sop, input bit tv, input logic [7:0] rmax);
        int k, b, r, rm;
        bit fetch_req;
        exp_t e;
        bram_t t;
        logic [COL-1:0][IW-1:0] cols;
        @(posedge i_clk);
        #1;
        for (int c = 0; c < COL; c++) cols[c] = $urandom;
        bus.sop       = sop;
        bus.in_tvalid = tv;
        bus.rbg_max   = rmax;
        bus.in_data   = cols;
        while (bram_q.size() != 0 && bram_q[0].cyc < cyc) void'(bram_q.pop_front());
        if (bram_q.size() != 0 && bram_q[0].cyc == cyc) begin
            t = bram_q.pop_front();
            bus.beam_index = t.v;
        end else begin
            for (int l = 0; l < NBEAM; l++) bus.beam_index[l] = 8'($urandom);
        end

        fetch_req = 1'b0;
        k  = sop ? 0 : m_beats;
        rm = sop ? int'(rmax) : m_rbg_max;
        b  = k % RBG_LEN;
        r  = (k / RBG_LEN) % (rm + 1);
        if (tv) begin
            if (b == 0) begin
                if (m_pending && cyc >= m_ready) begin
                    m_active  = m_shadow;
                    m_pending = 1'b0;
`ifdef BEAM_SELECT_IDX_CHECK_EN
                    for (int l = 0; l < NBEAM; l++) if (int'(m_active[l]) >= COL) m_err[1] = 1'b1;
`endif
                    if (r < rm) fetch_req = 1'b1;
                end else begin
                    m_err[0] = 1'b1;
                end
            end
            for (int l = 0; l < NBEAM; l++) begin
`ifdef BEAM_SELECT_IDX_CHECK_EN
                e.data[l] = (int'(m_active[l]) < COL) ? cols[int'(m_active[l])] : '0;
`else
                e.data[l] = cols[int'(m_active[l]) % COL];
`endif
            end
            e.ids = m_active;
            e.sop = (b == 0) && (r == 0);
            e.eop = (b == RBG_LEN - 1) && (r == rm);
            e.rbg = 8'(r);
            m_beats = k + 1;
        end else if (sop) begin
            m_beats = 0;
        end
        if (sop) begin
            if (m_pending && cyc < m_ready) m_err[0] = 1'b1;
            m_rbg_max = int'(rmax);
            fetch_req = 1'b1;
        end
        if (fetch_req) begin
            m_pending = 1'b1;
            m_ready   = cyc + RD_LAT + 2;
            m_shadow  = tab[m_fetch % NFETCH];
            m_fetch++;
            rden_q.push_back(cyc + 1);
        end
        if (tv) begin
            e.err = m_err;
            sb_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_reset       = 1'b1;
        bus.sop       = 1'b0;
        bus.in_tvalid = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        model_reset();
        chk("rst_tvalid", 512'(bus.out_tvalid), 512'(0));
        chk("rst_rden", 512'(bus.bid_rden), 512'(0));
        chk("rst_err", 512'(bus.err), 512'(0));
        chk("rst_data", bus.out_data, 512'(0));
        chk("rst_beam_id", 512'(bus.beam_id), 512'(0));
        chk("rst_flags", 512'({bus.out_sop, bus.out_eop, bus.rbg_idx}), 512'(0));
    endtask

    task automatic run_symbol(input int rmax, input int delay, input int gap_pct, input int nbeats);
        int total, sent;
        total = (nbeats < 0) ? RBG_LEN * (rmax + 1) : nbeats;
        sent  = 0;
        step(1'b1, delay == 0, 8'(rmax));
        if (delay == 0) sent = 1;
        for (int i = 1; i < delay; i++) step(1'b0, 1'b0, 8'(rmax));
        while (sent < total) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                step(1'b0, 1'b0, 8'(rmax));
            end else begin
                step(1'b0, 1'b1, 8'(rmax));
                sent++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        i_reset        = 1'b1;
        bus.sop        = 1'b0;
        bus.in_tvalid  = 1'b0;
        bus.rbg_max    = '0;
        bus.in_data    = '0;
        bus.beam_index = '0;
        for (int l = 0; l < NBEAM; l++) begin
            tab[0][l] = 8'(63 - l);
            tab[1][l] = 8'(l);
            tab[2][l] = 8'd5;
        end
        for (int f = 3; f < NFETCH; f++)
            for (int l = 0; l < NBEAM; l++)
                tab[f][l] = ($urandom_range(7) == 0) ? 8'($urandom_range(79)) : 8'($urandom_range(63));
        tab[3][3] = 8'd70;
        model_reset();

        do_reset();

        run_symbol(2, 6, 0, -1);
        idle(6);
        run_symbol(0, 7, 10, -1);
        idle(6);
        run_symbol(3, 6 + int'($urandom_range(3)), 20, -1);
        idle(6);
        run_symbol(1, 9, 0, -1);
        idle(6);

        step(1'b1, 1'b0, 8'd1);
        step(1'b0, 1'b0, 8'd1);
        run_symbol(1, 6, 5, -1);
        idle(6);
        do_reset();

        run_symbol(1, 3, 0, -1);
        idle(6);
        do_reset();

        run_symbol(1, 0, 0, -1);
        idle(6);
        do_reset();

        run_symbol(1, 6, 0, 21);
        do_reset();
        run_symbol(1, 6, 15, -1);
        idle(10);

        chk("sb_drained", 512'(sb_q.size()), 512'(0));
        chk("rden_drained", 512'(rden_q.size()), 512'(0));
        chk("rden_count", 512'(bram_n), 512'(m_fetch));
        chk("err_final", 512'(bus.err), 512'(m_err));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/beam_select_gather.md
# beam_select_gather

Consumer end of the sorted-beam-index store. Per RBG it issues one-cycle read requests to the beam sorter's index BRAM, latches the 16 returned beam indices (top-16 by power), and gathers those 16 columns out of the COL-wide antenna-beam stream. The result is a 16-lane reduced stream for downstream PUSCH processing. It sits directly after the beam sorter's index output and before the reduced-dimension equalisation path.

## Interface
- IW, 32, sample width per column
- COL, 64, input columns (beams)
- NBEAM, 16, output lanes / indices per RBG
- RD_LAT, 4, cycles from o_bid_rden pulse to valid i_beam_index
- RBG_LEN, 48, valid beats per RBG
- Reset/clock (already decided): reset i_reset, synchronous, active-high; clock i_clk.
- i_clk  in  1  clock
- i_reset  in  1  sync active-high reset
- i_sop  in  1  start-of-symbol pulse; restarts RBG/beat counters and fetch
- i_data  in  [COL][IW]  input columns, valid with i_tvalid
- i_tvalid  in  1  input beat valid (no backpressure)
- i_rbg_max  in  8  last RBG number of the symbol (RBGs 0..i_rbg_max)
- o_bid_rden  out  1  one-cycle index read request; each pulse advances producer address
- i_beam_index  in  [NBEAM][8]  beam indices, valid exactly RD_LAT cycles after o_bid_rden
- o_data  out  [NBEAM][IW]  gathered samples
- o_beam_id  out  [NBEAM][8]  active indices for the beat on o_data
- o_tvalid  out  1  output beat valid
- o_sop / o_eop  out  1  first beat of RBG 0 / last beat of RBG i_rbg_max
- o_rbg_idx  out  8  RBG number of current output beat
- o_err  out  2  sticky: bit0 index underrun/fetch violation, bit1 index out of range

## Operation
- Fetch FSM: F_IDLE, F_WAIT, F_FULL.
  - F_IDLE: on i_sop, pulse o_bid_rden next cycle, load latency counter, -> F_WAIT.
  - F_WAIT: counter counts RD_LAT; on expiry capture i_beam_index into shadow register, -> F_FULL.
  - F_FULL: on first beat of an RBG, shadow -> active; if that RBG < i_rbg_max, pulse o_bid_rden next cycle and -> F_WAIT; else -> F_IDLE.
- Beat counter 0..RBG_LEN-1 increments per i_tvalid; wraps to 0 and increments RBG counter; RBG counter 0..i_rbg_max, wraps to 0.
- Gather: lane k outputs i_data[active[k]]; o_beam_id[k] = active[k].
- Underrun: first beat of an RBG arriving when FSM not F_FULL -> set o_err[0], keep stale active indices, FSM unchanged.
- i_sop while F_WAIT: set o_err[0], counters cleared, fetch restarts (new o_bid_rden).
- i_sop and i_tvalid same cycle: beat treated as beat 0 of RBG 0.
- i_rbg_max sampled on i_sop; mid-symbol changes ignored.

## Timing
- Reset: all outputs 0, FSM F_IDLE, counters 0, shadow/active 0, o_err cleared (reset only clears it).
- o_tvalid/o_data/o_beam_id/o_sop/o_eop/o_rbg_idx: 1-cycle registered latency from i_tvalid.
- Earliest legal first beat: i_sop + RD_LAT + 2 cycles.
- Requirement: RBG_LEN >= RD_LAT + 2, so each prefetch completes within an RBG.
- o_bid_rden never asserted two consecutive cycles; at most i_rbg_max+1 pulses per symbol.

## Configuration
- BEAM_SELECT_IDX_CHECK_EN defined: indices >= COL force lane output 0 and set o_err[1] on the swap cycle.
- Undefined: index taken modulo COL (low $clog2(COL) bits), o_err[1] tied 0.

## Structure
- Package beam_pkg: NBEAM, BIDX_W=8, typedef beam_idx_vec_t ([NBEAM][BIDX_W]), fetch state enum.
- Sub-module beam_gather_lane: registered COL:1 mux plus optional range check, instantiated NBEAM times.

## Test plan
- Basic: i_sop, i_rbg_max=2, indices {63..48},{0..15},{5 repeated} at each fetch -> exactly 3 rden pulses, lane0 = col63/col0/col5 per RBG, o_eop on beat 143.
- Latency: rden at cycle t, index changes at t+RD_LAT -> captured at t+4, not t+3.
- Underrun: first beat at i_sop+3 -> o_err=01, stale (reset) indices, output still valid.
- Mid-fetch i_sop: second i_sop 2 cycles after first -> o_err[0]=1, new rden, counters restart at 0.
- Range (macro on): index 70 in lane 3 -> o_data[3]=0, o_err[1]=1; macro off -> column 6 selected.
- Reset mid-RBG: i_reset at beat 20 -> all outputs 0 next cycle, next i_sop restarts cleanly.
